// File: rtl/rename_table_pkg.sv
// Shared types and constants for register renaming; the free list uses the same tag type.
package rename_table_pkg;
  localparam int AREG_W = 5;
  localparam int TAG_W = 7;
  localparam logic [TAG_W-1:0] TAG_NONE = 7'h40;

  // bit6 set means no physical register (x0); bits 5:0 are the physical index
  typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/rename_bypass.sv
// Per-slot selector: returns the tag of the latest earlier slot writing the same register,
// falling back to the slot's base tag when no earlier slot matches.
module rename_bypass
  import rename_table_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        wr_valid,
  input  logic [N*AREG_W-1:0] wr_reg,
  input  logic [N*TAG_W-1:0]  wr_tag,
  input  logic [N*AREG_W-1:0] rd_reg,
  input  logic [N*TAG_W-1:0]  base_tag,
  output logic [N*TAG_W-1:0]  out_tag
);

  always_comb begin
    out_tag = base_tag;
    for (int i = 1; i < N; i++) begin
      // ascending j, so the latest matching earlier slot is the last to assign
      for (int j = 0; j < i; j++) begin
        if (wr_valid[j] && (wr_reg[j*AREG_W +: AREG_W] == rd_reg[i*AREG_W +: AREG_W])) begin
          out_tag[i*TAG_W +: TAG_W] = wr_tag[j*TAG_W +: TAG_W];
        end
      end
    end
  end

endmodule

// File: rtl/rename_table.sv
// Register alias table: speculative and committed maps, in-group bypass for sources
// and commit previous-tag lookup, mispredict restore of spec from com.
module rename_table
  import rename_table_pkg::*;
#(
  parameter int NUM_UOPS  = 4,
  parameter int NUM_AREGS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       IN_mispr,
  input  logic [NUM_UOPS-1:0]        IN_renValid,
  input  logic [NUM_UOPS*AREG_W-1:0] IN_renRd,
  input  logic [NUM_UOPS*AREG_W-1:0] IN_renRs1,
  input  logic [NUM_UOPS*AREG_W-1:0] IN_renRs2,
  input  logic [NUM_UOPS*6-1:0]      IN_issueTags,
  input  logic [NUM_UOPS-1:0]        IN_issueTagsValid,
  output logic [NUM_UOPS-1:0]        OUT_tagConsume,
  output logic                       OUT_stall,
  output logic [NUM_UOPS-1:0]        OUT_valid,
  output logic [NUM_UOPS*TAG_W-1:0]  OUT_rdTag,
  output logic [NUM_UOPS*TAG_W-1:0]  OUT_rs1Tag,
  output logic [NUM_UOPS*TAG_W-1:0]  OUT_rs2Tag,
  input  logic [NUM_UOPS-1:0]        IN_commitValid,
  input  logic [NUM_UOPS*AREG_W-1:0] IN_commitRd,
  input  logic [NUM_UOPS*TAG_W-1:0]  IN_commitTag,
  output logic [NUM_UOPS*TAG_W-1:0]  OUT_commitPrevTags
);

  tag_t spec_map [NUM_AREGS];
  tag_t com_map  [NUM_AREGS];
  tag_t com_next [NUM_AREGS];

  logic [NUM_UOPS-1:0]       writer;
  logic [NUM_UOPS-1:0]       commit_wr;
  logic                      accept;
  logic [NUM_UOPS*TAG_W-1:0] rd_tag;
  logic [NUM_UOPS*TAG_W-1:0] rs1_base;
  logic [NUM_UOPS*TAG_W-1:0] rs2_base;
  logic [NUM_UOPS*TAG_W-1:0] com_base;
  logic [NUM_UOPS*TAG_W-1:0] rs1_tag;
  logic [NUM_UOPS*TAG_W-1:0] rs2_tag;

  // Handshake: the group is taken only when every writer has a valid offered tag and no
  // mispredict is present; OUT_tagConsume then pulses for exactly the writers that took a tag.
  always_comb begin
    writer    = '0;
    commit_wr = '0;
    rd_tag    = '0;
    rs1_base  = '0;
    rs2_base  = '0;
    com_base  = '0;
    for (int i = 0; i < NUM_UOPS; i++) begin
      writer[i]    = IN_renValid[i] && (IN_renRd[i*AREG_W +: AREG_W] != '0);
      commit_wr[i] = IN_commitValid[i] && (IN_commitRd[i*AREG_W +: AREG_W] != '0);
      rd_tag[i*TAG_W +: TAG_W] = writer[i] ? {1'b0, IN_issueTags[i*6 +: 6]} : TAG_NONE;
      rs1_base[i*TAG_W +: TAG_W] = (IN_renRs1[i*AREG_W +: AREG_W] == '0) ? TAG_NONE
                                   : spec_map[IN_renRs1[i*AREG_W +: AREG_W]];
      rs2_base[i*TAG_W +: TAG_W] = (IN_renRs2[i*AREG_W +: AREG_W] == '0) ? TAG_NONE
                                   : spec_map[IN_renRs2[i*AREG_W +: AREG_W]];
      com_base[i*TAG_W +: TAG_W] = (IN_commitRd[i*AREG_W +: AREG_W] == '0) ? TAG_NONE
                                   : com_map[IN_commitRd[i*AREG_W +: AREG_W]];
    end
  end

  assign OUT_stall      = |(writer & ~IN_issueTagsValid);
  assign accept         = !OUT_stall && !IN_mispr;
  assign OUT_tagConsume = accept ? writer : '0;

  rename_bypass #(.N(NUM_UOPS)) u_byp_rs1 (
    .wr_valid (writer),
    .wr_reg   (IN_renRd),
    .wr_tag   (rd_tag),
    .rd_reg   (IN_renRs1),
    .base_tag (rs1_base),
    .out_tag  (rs1_tag)
  );

  rename_bypass #(.N(NUM_UOPS)) u_byp_rs2 (
    .wr_valid (writer),
    .wr_reg   (IN_renRd),
    .wr_tag   (rd_tag),
    .rd_reg   (IN_renRs2),
    .base_tag (rs2_base),
    .out_tag  (rs2_tag)
  );

  rename_bypass #(.N(NUM_UOPS)) u_byp_com (
    .wr_valid (commit_wr),
    .wr_reg   (IN_commitRd),
    .wr_tag   (IN_commitTag),
    .rd_reg   (IN_commitRd),
    .base_tag (com_base),
    .out_tag  (OUT_commitPrevTags)
  );

  // Committed map after this cycle's commits; also the restore source on mispredict
  always_comb begin
    for (int a = 0; a < NUM_AREGS; a++) com_next[a] = com_map[a];
    for (int i = 0; i < NUM_UOPS; i++) begin
      if (commit_wr[i]) com_next[IN_commitRd[i*AREG_W +: AREG_W]] = IN_commitTag[i*TAG_W +: TAG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_AREGS; a++) begin
        spec_map[a] <= TAG_NONE;
        com_map[a]  <= TAG_NONE;
      end
      OUT_valid  <= '0;
      OUT_rdTag  <= {NUM_UOPS{TAG_NONE}};
      OUT_rs1Tag <= {NUM_UOPS{TAG_NONE}};
      OUT_rs2Tag <= {NUM_UOPS{TAG_NONE}};
    end else begin
      for (int a = 0; a < NUM_AREGS; a++) com_map[a] <= com_next[a];
      if (IN_mispr) begin
        for (int a = 0; a < NUM_AREGS; a++) spec_map[a] <= com_next[a];
      end else if (accept) begin
        for (int i = 0; i < NUM_UOPS; i++) begin
          if (writer[i]) spec_map[IN_renRd[i*AREG_W +: AREG_W]] <= rd_tag[i*TAG_W +: TAG_W];
        end
      end
      OUT_valid <= accept ? IN_renValid : '0;
      if (accept) begin
        OUT_rdTag  <= rd_tag;
        OUT_rs1Tag <= rs1_tag;
        OUT_rs2Tag <= rs2_tag;
      end
    end
  end

endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table: hand-computed expectations checked with immediate assertions.
module tb_rename_table;
  import rename_table_pkg::*;

  localparam int NU = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            IN_mispr;
  logic [NU-1:0]   IN_renValid;
  logic [NU*5-1:0] IN_renRd, IN_renRs1, IN_renRs2;
  logic [NU*6-1:0] IN_issueTags;
  logic [NU-1:0]   IN_issueTagsValid;
  logic [NU-1:0]   OUT_tagConsume;
  logic            OUT_stall;
  logic [NU-1:0]   OUT_valid;
  logic [NU*7-1:0] OUT_rdTag, OUT_rs1Tag, OUT_rs2Tag;
  logic [NU-1:0]   IN_commitValid;
  logic [NU*5-1:0] IN_commitRd;
  logic [NU*7-1:0] IN_commitTag;
  logic [NU*7-1:0] OUT_commitPrevTags;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rename_table #(.NUM_UOPS(NU), .NUM_AREGS(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .IN_mispr           (IN_mispr),
    .IN_renValid        (IN_renValid),
    .IN_renRd           (IN_renRd),
    .IN_renRs1          (IN_renRs1),
    .IN_renRs2          (IN_renRs2),
    .IN_issueTags       (IN_issueTags),
    .IN_issueTagsValid  (IN_issueTagsValid),
    .OUT_tagConsume     (OUT_tagConsume),
    .OUT_stall          (OUT_stall),
    .OUT_valid          (OUT_valid),
    .OUT_rdTag          (OUT_rdTag),
    .OUT_rs1Tag         (OUT_rs1Tag),
    .OUT_rs2Tag         (OUT_rs2Tag),
    .IN_commitValid     (IN_commitValid),
    .IN_commitRd        (IN_commitRd),
    .IN_commitTag       (IN_commitTag),
    .OUT_commitPrevTags (OUT_commitPrevTags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] slot7(input logic [NU*7-1:0] v, input int s);
    return v[s*7 +: 7];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IN_mispr          = 1'b0;
    IN_renValid       = '0;
    IN_renRd          = '0;
    IN_renRs1         = '0;
    IN_renRs2         = '0;
    IN_issueTags      = '0;
    IN_issueTagsValid = '1;
    IN_commitValid    = '0;
    IN_commitRd       = '0;
    IN_commitTag      = '0;
  endtask

  task automatic ren(input int s, input int rd, input int rs1, input int rs2, input int tag);
    IN_renValid[s]        = 1'b1;
    IN_renRd[s*5 +: 5]    = 5'(rd);
    IN_renRs1[s*5 +: 5]   = 5'(rs1);
    IN_renRs2[s*5 +: 5]   = 5'(rs2);
    IN_issueTags[s*6 +: 6] = 6'(tag);
  endtask

  task automatic com(input int s, input int rd, input int tag);
    IN_commitValid[s]      = 1'b1;
    IN_commitRd[s*5 +: 5]  = 5'(rd);
    IN_commitTag[s*7 +: 7] = 7'(tag);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_valid", 32'(OUT_valid), 32'h0);
    chk("reset_rdtag", 32'(OUT_rdTag), 32'h0810_2040);
    chk("reset_rs1tag", 32'(OUT_rs1Tag), 32'h0810_2040);
    chk("reset_rs2tag", 32'(OUT_rs2Tag), 32'h0810_2040);
    chk("reset_stall", 32'(OUT_stall), 32'h0);
    chk("reset_consume", 32'(OUT_tagConsume), 32'h0);

    // non-writing uop reading r5 from a fresh map
    tick();
    clear_inputs();
    ren(0, 0, 5, 0, 0);
    #1;
    chk("nowr_consume", 32'(OUT_tagConsume), 32'h0);
    tick();
    chk("nowr_valid", 32'(OUT_valid), 32'b0001);
    chk("nowr_rs1", 32'(slot7(OUT_rs1Tag, 0)), 32'h40);
    chk("nowr_rd", 32'(slot7(OUT_rdTag, 0)), 32'h40);

    // group rd={3,3,0,7}, same-group sources of r3
    clear_inputs();
    ren(0, 3, 0, 0, 10);
    ren(1, 3, 3, 0, 11);
    ren(2, 0, 0, 0, 12);
    ren(3, 7, 0, 3, 13);
    #1;
    chk("grp_stall", 32'(OUT_stall), 32'h0);
    chk("grp_consume", 32'(OUT_tagConsume), 32'b1011);
    tick();
    chk("grp_valid", 32'(OUT_valid), 32'b1111);
    chk("grp_rd0", 32'(slot7(OUT_rdTag, 0)), 32'h0A);
    chk("grp_rd1", 32'(slot7(OUT_rdTag, 1)), 32'h0B);
    chk("grp_rd2", 32'(slot7(OUT_rdTag, 2)), 32'h40);
    chk("grp_rd3", 32'(slot7(OUT_rdTag, 3)), 32'h0D);
    chk("grp_byp_rs1_1", 32'(slot7(OUT_rs1Tag, 1)), 32'h0A);
    chk("grp_byp_rs2_3", 32'(slot7(OUT_rs2Tag, 3)), 32'h0B);

    // intra-group bypass of r4 plus spec reads of r3/r7 from the previous group
    clear_inputs();
    ren(0, 4, 0, 0, 20);
    ren(1, 0, 3, 4, 0);
    ren(2, 0, 4, 7, 0);
    #1;
    chk("intra_consume", 32'(OUT_tagConsume), 32'b0001);
    tick();
    chk("intra_valid", 32'(OUT_valid), 32'b0111);
    chk("intra_rd0", 32'(slot7(OUT_rdTag, 0)), 32'h14);
    chk("intra_rs2_1", 32'(slot7(OUT_rs2Tag, 1)), 32'h14);
    chk("intra_rs1_2", 32'(slot7(OUT_rs1Tag, 2)), 32'h14);
    chk("spec_rs1_1", 32'(slot7(OUT_rs1Tag, 1)), 32'h0B);
    chk("spec_rs2_2", 32'(slot7(OUT_rs2Tag, 2)), 32'h0D);

    // stall: slot3 writer lacks a tag, whole group rejected
    clear_inputs();
    IN_issueTagsValid = 4'b0111;
    ren(0, 5, 0, 0, 30);
    ren(3, 9, 0, 0, 31);
    #1;
    chk("stall_flag", 32'(OUT_stall), 32'h1);
    chk("stall_consume", 32'(OUT_tagConsume), 32'h0);
    tick();
    chk("stall_valid", 32'(OUT_valid), 32'h0);
    clear_inputs();
    ren(0, 0, 9, 5, 0);
    tick();
    chk("stall_r9", 32'(slot7(OUT_rs1Tag, 0)), 32'h40);
    chk("stall_r5", 32'(slot7(OUT_rs2Tag, 0)), 32'h40);

    // commit r3->0B, speculative r3->0x21, then mispredict restores
    clear_inputs();
    com(0, 3, 'h0B);
    #1;
    chk("cmt_prev_r3", 32'(slot7(OUT_commitPrevTags, 0)), 32'h40);
    tick();
    clear_inputs();
    ren(0, 3, 0, 0, 'h21);
    tick();
    clear_inputs();
    IN_mispr = 1'b1;
    ren(0, 3, 0, 0, 'h22);
    #1;
    chk("mispr_consume", 32'(OUT_tagConsume), 32'h0);
    tick();
    chk("mispr_valid", 32'(OUT_valid), 32'h0);
    clear_inputs();
    ren(0, 0, 3, 4, 0);
    tick();
    chk("restore_r3", 32'(slot7(OUT_rs1Tag, 0)), 32'h0B);
    chk("restore_r4", 32'(slot7(OUT_rs2Tag, 0)), 32'h40);

    // commit group with repeated rd and an x0 commit
    clear_inputs();
    com(0, 6, 'h01);
    com(1, 6, 'h02);
    com(2, 0, 'h05);
    #1;
    chk("cprev_0", 32'(slot7(OUT_commitPrevTags, 0)), 32'h40);
    chk("cprev_1", 32'(slot7(OUT_commitPrevTags, 1)), 32'h01);
    chk("cprev_x0", 32'(slot7(OUT_commitPrevTags, 2)), 32'h40);
    tick();

    // commit + mispredict + rename in one cycle
    clear_inputs();
    com(0, 6, 'h03);
    com(3, 3, 'h11);
    IN_mispr = 1'b1;
    ren(0, 6, 0, 0, 'h3F);
    #1;
    chk("cprev_r6", 32'(slot7(OUT_commitPrevTags, 0)), 32'h02);
    chk("cprev_r3", 32'(slot7(OUT_commitPrevTags, 3)), 32'h0B);
    chk("combo_consume", 32'(OUT_tagConsume), 32'h0);
    tick();
    chk("combo_valid", 32'(OUT_valid), 32'h0);
    clear_inputs();
    ren(0, 0, 6, 3, 0);
    tick();
    chk("combo_r6", 32'(slot7(OUT_rs1Tag, 0)), 32'h03);
    chk("combo_r3", 32'(slot7(OUT_rs2Tag, 0)), 32'h11);

    clear_inputs();
    tick();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/rename_table.md
# rename_table

Register alias table sitting between decode and the physical-tag free list. It maps architectural destination registers of up to NUM_UOPS uops per cycle onto free physical tags and looks up source operand tags. It keeps a committed map so the speculative map can be restored on a mispredict. At commit it returns each retiring uop's previous tag so the free list can release it, and it drives the free list's per-slot tag-consume strobes.

## Interface
- NUM_UOPS, 4, uops renamed/committed per cycle
- NUM_AREGS, 32, architectural registers; x0 hardwired
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- IN_mispr  in  1  flush: restore speculative map from committed map
- IN_renValid  in  NUM_UOPS  uop i presented for rename
- IN_renRd / IN_renRs1 / IN_renRs2  in  NUM_UOPS*5  arch dest / sources per slot
- IN_issueTags  in  NUM_UOPS*6  free-list tag offered to slot i
- IN_issueTagsValid  in  NUM_UOPS  offered tag i is usable
- OUT_tagConsume  out  NUM_UOPS  slot i consumed its offered tag (free list issueValid)
- OUT_stall  out  1  rename group not accepted this cycle
- OUT_valid  out  NUM_UOPS  registered renamed uop valid
- OUT_rdTag / OUT_rs1Tag / OUT_rs2Tag  out  NUM_UOPS*7  registered tags; bit6=1 means no physical reg (x0), bits5:0 index
- IN_commitValid  in  NUM_UOPS  uop i commits
- IN_commitRd  in  NUM_UOPS*5  committed arch dest
- IN_commitTag  in  NUM_UOPS*7  committed physical dest tag
- OUT_commitPrevTags  out  NUM_UOPS*7  combinational previous committed mapping of IN_commitRd[i]

## Operation
- Two maps, spec[NUM_AREGS] and com[NUM_AREGS], 7 bits each. Reset: all entries 7'h40. x0 always reads 7'h40 and is never written.
- Writer: slot i with IN_renValid[i] && rd!=0.
- OUT_stall = any writer i with !IN_issueTagsValid[i]. A stall rejects the whole group.
- Accept = !OUT_stall && !IN_mispr. When accepted, OUT_tagConsume[i] = writer i; otherwise it is 0.
- Writer i gets rdTag {0, IN_issueTags[i]}. Non-writer valid uops get 7'h40.
- Source lookup for slot i: take the latest earlier writer j<i in the same group with the same rd. If none, use spec[rs]. rs=0 gives 7'h40.
- Spec update on accept: for each rd, the highest-index writer wins.
- Commit: for each valid i with rd!=0, com[rd] <= IN_commitTag[i]; highest index wins.
- OUT_commitPrevTags[i]: if an earlier valid commit j<i in the group has the same rd, use the latest such IN_commitTag[j]; else com[rd]. rd=0 gives 7'h40. Only meaningful when IN_commitValid[i].
- Mispredict: spec <= com including same-cycle commit updates. The rename group that cycle is dropped.

## Timing
- Rename lookup is combinational. OUT_valid and the OUT_*Tag outputs are registered with 1-cycle latency. OUT_valid[i] = accepted && IN_renValid[i].
- The cycle after a stall or mispredict, OUT_valid = 0.
- Reset values: OUT_valid 0, all registered tags 7'h40. OUT_stall and OUT_tagConsume are combinational and are 0 when no uop is valid.
- OUT_commitPrevTags is combinational, the same cycle as commit, from com before the update.
- The cycle after a rename, sources see the new spec mappings. There is no forwarding across cycles beyond the register update.
- Rename, commit and mispredict may all occur in one cycle. Commit is applied, spec is restored from the updated com, and rename is discarded.

## Structure
- Shared package: AREG_W=5, TAG_W=7, TAG_NONE=7'h40, and the tag typedef, shared with the free list.
- One sub-module, rename_bypass: the priority "latest earlier slot with same reg" selector. Instantiate it for rs1, rs2 and the commit prev-tag path.

## Test plan
- Reset, then rename slot0 rs1=5 -> OUT_rs1Tag[0]=7'h40, OUT_valid=0001 next cycle.
- Group rd={3,3,0,7}, tags {10,11,12,13}, all valid -> rdTag {0A,0B,40,0D}; tagConsume=1011; spec[3]=0B.
- Intra-group: slot0 rd=4 tag 20, slot2 rs1=4, slot1 rs2=4 -> next cycle rs1Tag[2]=rs2Tag[1]=0x14.
- IN_issueTagsValid=0111, slot3 writes rd=9 -> OUT_stall=1, tagConsume=0000, OUT_valid=0 next cycle; spec unchanged.
- Commit rd=3 tag 0B, then mispredict after speculative rd=3 tag 0x21 -> the next read of r3 gives 0x0B.
- Commit group rd={6,6}, tags {01,02}, com[6]=7'h40 -> OUT_commitPrevTags {40,01}; com[6]=02 afterwards.
